// File: rtl/programmable_counter_if.sv
// Control/status bundle for programmable_counter.
// Latency: none, wires only; the counter registers every status output.
// Backpressure: none; all controls are sampled each clock edge.
//
// Controls (master -> slave): count_en, count_clr, count_dir, load,
//   load_val[N], limit[N], mode[2], flag_clr
// Status (slave -> master): count[N], overflow, underflow, ovf_sticky,
//   unf_sticky, done
interface programmable_counter_if #(
  parameter int N = 8
);
  logic         count_en;
  logic         count_clr;
  logic         count_dir;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] limit;
  logic [1:0]   mode;
  logic         flag_clr;
  logic [N-1:0] count;
  logic         overflow;
  logic         underflow;
  logic         ovf_sticky;
  logic         unf_sticky;
  logic         done;

  modport master (
    output count_en, count_clr, count_dir, load, load_val, limit, mode, flag_clr,
    input  count, overflow, underflow, ovf_sticky, unf_sticky, done
  );

  modport slave (
    input  count_en, count_clr, count_dir, load, load_val, limit, mode, flag_clr,
    output count, overflow, underflow, ovf_sticky, unf_sticky, done
  );
endinterface

// File: rtl/programmable_counter.sv
// Up/down counter over 0..limit with wrap, saturate and one-shot modes.
// Latency: one cycle from the sampled controls to count and all flags.
// Backpressure: none; one step is accepted every enabled cycle while in RUN.
//
// Ports: clk, rst (async, active-high); bus (slave modport) carries
//   the step/clear/load controls, limit, mode and flag_clr in, and
//   count, overflow/underflow pulses, sticky flags and done out.
module programmable_counter #(
  parameter int           N       = 8,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input logic                   clk,
  input logic                   rst,
  programmable_counter_if.slave bus
);

  localparam logic [N-1:0] ONE = N'(1);

  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;
  logic         ovf_st_q, unf_st_q;
  logic         hold_at_bound;
  logic         stop_at_bound;

  // Saturate and one-shot both park at the bound; only one-shot also stops.
  // Mode 11 is reserved and falls through to wrap.
  assign hold_at_bound = (bus.mode == MODE_SAT) || (bus.mode == MODE_ONESHOT);
  assign stop_at_bound = (bus.mode == MODE_ONESHOT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (bus.count_clr) begin
      count_d = '0;
      state_d = RUN;
    end else if (bus.load) begin
      count_d = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
      state_d = RUN;
    end else if (bus.count_en && (state_q == RUN)) begin
      if (bus.count_dir) begin
        if (count_q < bus.limit) begin
          count_d = count_q + ONE;
        end else begin
          ovf_d   = 1'b1;
          count_d = hold_at_bound ? bus.limit : '0;
          if (stop_at_bound) state_d = DONE;
        end
      end else begin
        if (count_q > bus.limit) begin
          // Limit was lowered under the count: pull back into range quietly.
          count_d = bus.limit;
        end else if (count_q != '0) begin
          count_d = count_q - ONE;
        end else begin
          unf_d   = 1'b1;
          count_d = hold_at_bound ? '0 : bus.limit;
          if (stop_at_bound) state_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= RST_VAL;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      ovf_st_q <= 1'b0;
      unf_st_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      // A new event outranks a simultaneous flag_clr.
      ovf_st_q <= ovf_d | (ovf_st_q & ~bus.flag_clr);
      unf_st_q <= unf_d | (unf_st_q & ~bus.flag_clr);
    end
  end

  assign bus.count      = count_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
  assign bus.ovf_sticky = ovf_st_q;
  assign bus.unf_sticky = unf_st_q;
  assign bus.done       = (state_q == DONE);

endmodule

// File: tb/tb_programmable_counter.sv
// Self-checking bench for programmable_counter: directed scenarios then
// random traffic, every cycle compared against a behavioural model.
// Ports: none (top-level bench).
module tb_programmable_counter;

  localparam int           N       = 8;
  localparam logic [N-1:0] RST_VAL = 8'd3;

  logic clk;
  logic rst;

  programmable_counter_if #(.N(N)) bus ();

  programmable_counter #(.N(N), .RST_VAL(RST_VAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert;
  int n_fail;

  // Reference model state.
  int m_count;
  bit m_done, m_ovf, m_unf, m_os, m_us;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = int'(RST_VAL);
    m_done  = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_os    = 1'b0;
    m_us    = 1'b0;
  endtask

  // One clock edge of the counter's rules, in plain integer arithmetic.
  task automatic model_step();
    int  lim;
    bit  parks;
    lim   = int'(bus.limit);
    parks = (bus.mode == 2'd1) || (bus.mode == 2'd2);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (bus.count_clr) begin
      m_count = 0;
      m_done  = 1'b0;
    end else if (bus.load) begin
      m_count = (int'(bus.load_val) < lim) ? int'(bus.load_val) : lim;
      m_done  = 1'b0;
    end else if (bus.count_en && !m_done) begin
      if (bus.count_dir) begin
        if (m_count < lim) m_count = m_count + 1;
        else begin
          m_ovf   = 1'b1;
          m_count = parks ? lim : 0;
          m_done  = (bus.mode == 2'd2);
        end
      end else begin
        if (m_count > lim) m_count = lim;
        else if (m_count > 0) m_count = m_count - 1;
        else begin
          m_unf   = 1'b1;
          m_count = parks ? 0 : lim;
          m_done  = (bus.mode == 2'd2);
        end
      end
    end
    m_os = m_ovf || (m_os && !bus.flag_clr);
    m_us = m_unf || (m_us && !bus.flag_clr);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"},     bus.count,      m_count);
    chk({tag, ".overflow"},  bus.overflow,   m_ovf);
    chk({tag, ".underflow"}, bus.underflow,  m_unf);
    chk({tag, ".ovf_stky"},  bus.ovf_sticky, m_os);
    chk({tag, ".unf_stky"},  bus.unf_sticky, m_us);
    chk({tag, ".done"},      bus.done,       m_done);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_step();
    chk_all(tag);
  endtask

  task automatic set_in(input bit clr, input bit ld, input int lv, input bit en,
                        input bit dir, input int lim, input int md, input bit fclr);
    bus.count_clr = clr;
    bus.load      = ld;
    bus.load_val  = N'(lv);
    bus.count_en  = en;
    bus.count_dir = dir;
    bus.limit     = N'(lim);
    bus.mode      = 2'(md);
    bus.flag_clr  = fclr;
  endtask

  // Asserts rst between edges and checks the outputs before the next edge.
  task automatic async_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk_all(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int e_cnt[6];
    int e_flg[6];
    n_assert = 0;
    n_fail   = 0;

    // Reset state and first step after release.
    rst = 1'b1;
    set_in(0, 0, 0, 0, 1, 5, 0, 0);
    #1;
    model_reset();
    chk_all("reset");
    chk("reset.count_rstval", bus.count, 3);
    tick("reset_hold");
    rst = 1'b0;
    tick("idle_hold");
    set_in(0, 0, 0, 1, 1, 5, 0, 0);
    tick("first_step");
    chk("first_step.value", bus.count, 4);

    // Wrap up, limit 5.
    set_in(1, 0, 0, 0, 1, 5, 0, 0);
    tick("clr");
    set_in(0, 0, 0, 1, 1, 5, 0, 0);
    e_cnt = '{1, 2, 3, 4, 5, 0};
    for (int i = 0; i < 6; i++) begin
      tick("wrap_up");
      chk("wrap_up.seq", bus.count, e_cnt[i]);
      chk("wrap_up.ovf", bus.overflow, (i == 5) ? 1 : 0);
    end
    set_in(0, 0, 0, 0, 1, 5, 0, 0);
    tick("sticky_hold");
    chk("sticky_hold.ovf_stky", bus.ovf_sticky, 1);
    set_in(0, 0, 0, 0, 1, 5, 0, 1);
    tick("flag_clr");
    chk("flag_clr.ovf_stky", bus.ovf_sticky, 0);

    // Saturate down from 2.
    set_in(0, 1, 2, 0, 0, 5, 1, 0);
    tick("load2");
    set_in(0, 0, 0, 1, 0, 5, 1, 0);
    e_cnt = '{1, 0, 0, 0, 0, 0};
    e_flg = '{0, 0, 1, 1, 0, 0};
    for (int i = 0; i < 4; i++) begin
      tick("sat_down");
      chk("sat_down.seq", bus.count, e_cnt[i]);
      chk("sat_down.unf", bus.underflow, e_flg[i]);
    end

    // One-shot up, limit 3.
    set_in(1, 0, 0, 0, 1, 3, 2, 1);
    tick("clr2");
    set_in(0, 0, 0, 1, 1, 3, 2, 0);
    e_cnt = '{1, 2, 3, 3, 3, 3};
    e_flg = '{0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      tick("oneshot");
      chk("oneshot.seq", bus.count, e_cnt[i]);
      chk("oneshot.ovf", bus.overflow, e_flg[i]);
      chk("oneshot.done", bus.done, (i >= 3) ? 1 : 0);
    end
    set_in(0, 1, 9, 0, 1, 3, 2, 0);
    tick("oneshot_load");
    chk("oneshot_load.count", bus.count, 3);
    chk("oneshot_load.done", bus.done, 0);

    // clr beats load beats step; event beats flag_clr; limit 0.
    set_in(0, 1, 7, 0, 1, 9, 0, 0);
    tick("load7");
    set_in(1, 1, 4, 1, 1, 9, 0, 0);
    tick("clr_prio");
    chk("clr_prio.count", bus.count, 0);
    chk("clr_prio.ovf", bus.overflow, 0);
    set_in(0, 0, 0, 1, 1, 0, 0, 1);
    tick("lim0_up");
    chk("lim0_up.ovf_stky", bus.ovf_sticky, 1);
    chk("lim0_up.ovf", bus.overflow, 1);
    set_in(0, 0, 0, 1, 0, 0, 0, 0);
    tick("lim0_dn");
    chk("lim0_dn.unf", bus.underflow, 1);
    chk("lim0_dn.count", bus.count, 0);

    // Limit lowered under the count.
    set_in(0, 1, 200, 0, 1, 255, 0, 0);
    tick("load200");
    set_in(0, 0, 0, 1, 0, 10, 0, 0);
    tick("reenter");
    chk("reenter.count", bus.count, 10);
    chk("reenter.unf", bus.underflow, 0);
    set_in(0, 0, 0, 1, 1, 10, 0, 0);
    tick("reenter_up");
    chk("reenter_up.count", bus.count, 0);
    chk("reenter_up.ovf", bus.overflow, 1);

    // Full-range wrap behaves modulo 256.
    set_in(0, 1, 254, 0, 1, 255, 0, 0);
    tick("load254");
    set_in(0, 0, 0, 1, 1, 255, 0, 0);
    tick("full_255");
    tick("full_wrap");
    chk("full_wrap.count", bus.count, 0);

    // Async reset while in DONE.
    set_in(0, 0, 0, 1, 1, 0, 2, 0);
    tick("to_done");
    chk("to_done.done", bus.done, 1);
    set_in(0, 0, 0, 0, 1, 0, 2, 0);
    async_reset("async_rst");
    chk("async_rst.done", bus.done, 0);
    chk("async_rst.count", bus.count, 3);
    tick("post_rst");

    // Random traffic.
    for (int it = 0; it < 600; it++) begin
      int sel;
      bus.count_clr = ($urandom_range(0, 19) == 0);
      bus.load      = ($urandom_range(0, 11) == 0);
      bus.load_val  = N'($urandom);
      bus.count_en  = ($urandom_range(0, 3) != 0);
      bus.count_dir = 1'($urandom);
      if ($urandom_range(0, 9) == 0) bus.mode = 2'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        sel = $urandom_range(0, 4);
        case (sel)
          0:       bus.limit = '0;
          1:       bus.limit = '1;
          2:       bus.limit = N'($urandom_range(1, 7));
          default: bus.limit = N'($urandom);
        endcase
      end
      bus.flag_clr = ($urandom_range(0, 7) == 0);
      tick("rand");
      if ($urandom_range(0, 59) == 0) async_reset("rand_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/programmable_counter.md
PROGRAMMABLE_COUNTER -- requirements
Module: programmable_counter

Interface
REQ-001 Parameter N, 8, counter width in bits (N >= 2).
REQ-002 Parameter RST_VAL, 0, count value after reset (N bits, <= 2^N-1).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 count_en  input  1  enables one step per cycle.
REQ-006 count_clr  input  1  synchronous clear to 0.
REQ-007 count_dir  input  1  1 = up, 0 = down.
REQ-008 load  input  1  synchronous load of load_val.
REQ-009 load_val  input  N  value to load.
REQ-010 limit  input  N  upper bound; count range is 0..limit inclusive.
REQ-011 mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap).
REQ-012 flag_clr  input  1  clears sticky flags.
REQ-013 count  output  N  registered counter value.
REQ-014 overflow  output  1  registered one-cycle pulse on an up step past limit.
REQ-015 underflow  output  1  registered one-cycle pulse on a down step past 0.
REQ-016 ovf_sticky, unf_sticky  output  1 each  latched overflow/underflow history.
REQ-017 done  output  1  high while the FSM is in DONE.

Function
REQ-018 The FSM SHALL have states RUN and DONE; done = (state == DONE).
REQ-019 Per-cycle priority SHALL be count_clr > load > count step; clr and load both return FSM to RUN.
REQ-020 count_clr: count <= 0, no overflow/underflow pulse that cycle.
REQ-021 load: count <= min(load_val, limit); no pulse that cycle.
REQ-022 Step occurs only when count_en=1, state=RUN, and neither clr nor load is active; otherwise count holds.
REQ-023 Up step, count < limit: count+1; no pulse.
REQ-024 Up step, count >= limit: overflow=1 next cycle; wrap -> count <= 0; saturate -> count <= limit; one-shot -> count <= limit, FSM -> DONE.
REQ-025 Down step, count > limit: count <= limit, no pulse (re-entry into range after limit is lowered).
REQ-026 Down step, 0 < count <= limit: count-1; no pulse.
REQ-027 Down step, count == 0: underflow=1 next cycle; wrap -> count <= limit; saturate -> count holds 0; one-shot -> count holds 0, FSM -> DONE.
REQ-028 Saturate mode SHALL pulse overflow/underflow on every cycle a step is attempted at the bound.
REQ-029 In DONE, count_en SHALL be ignored; count holds; exits only via count_clr, load, or rst.
REQ-030 limit == 0: every enabled step is a boundary step (up -> overflow, down -> underflow); count stays 0.
REQ-031 limit == 2^N-1: wrap behaviour SHALL equal natural modulo-2^N counting.
REQ-032 overflow and underflow SHALL be mutually exclusive and each last exactly one cycle per event.
REQ-033 ovf_sticky/unf_sticky SHALL set in the same cycle the corresponding pulse is registered; flag_clr clears them; a new event in the same cycle as flag_clr wins (flag stays set).
REQ-034 mode and limit changes SHALL take effect on the next step with no extra latency; no internal pipeline.
REQ-035 All arithmetic in N bits; no output depends combinationally on inputs.

Reset
REQ-036 rst=1 SHALL asynchronously force count=RST_VAL, overflow=0, underflow=0, ovf_sticky=0, unf_sticky=0, state=RUN (done=0), including mid-count and in DONE.
REQ-037 After rst deasserts, the first step SHALL occur on the first posedge with count_en=1.

Verification
REQ-038 N=8, limit=5, mode=wrap, dir=up, en=1 from 0 -> 0,1,2,3,4,5,0; overflow high exactly the cycle count shows 0; ovf_sticky=1 until flag_clr.
REQ-039 limit=5, mode=saturate, dir=down from 2 -> 1,0,0,0; underflow pulses each cycle at 0 after first reaching 0; count never wraps.
REQ-040 limit=3, mode=one-shot, up from 0 -> 1,2,3,3 with done=1 and overflow once; further en ignored; load with load_val=9 -> count=3, done=0.
REQ-041 count=7, limit=9, same cycle clr=1, load=1 (load_val=4), en=1 -> count=0, no pulse; flag_clr with simultaneous overflow -> ovf_sticky stays 1.
REQ-042 count=200, limit lowered to 10: down step -> 10 no pulse; up step -> 0 with overflow (wrap).
REQ-043 rst asserted asynchronously between clock edges while in DONE -> count=RST_VAL, done=0, all flags 0 immediately, before next posedge.
